mod_exp_engine: RTL and testbench

MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

---
 rtl/mod_exp_engine.sv | 128 ++++++++++++
 tb/tb_mod_exp_engine.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine: right-to-left binary exponentiation built on a 32-cycle interleaved modular multiplier.
// Define MOD_EXP_CONST_TIME_EN to run the multiply step for every exponent bit (constant latency).
module mod_exp_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base,
    input  logic [31:0] exponent,
    input  logic [31:0] modulus,
    output logic [63:0] result,
    output logic        done,
    output logic        busy,
    output logic        err
);

`ifdef MOD_EXP_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REDUCE, MUL, SQR, NEXT, FIN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, cnt_q, idx_inc;
    logic [33:0] acc_q, acc_nxt;
    logic [31:0] res_q, sq_q;
    logic [31:0] base_q, exp_q, mod_q;
    logic [31:0] mul_a, mul_b;
    logic        err_q, mul_last;

    // One interleaved step: acc < m on entry, so 2*acc + a < 3m fits in 34 bits.
    function automatic logic [33:0] mm_step(input logic [33:0] acc, input logic [31:0] a,
                                            input logic bit_i, input logic [31:0] m);
        logic [33:0] t;
        t = {acc[32:0], 1'b0} + (bit_i ? {2'b00, a} : 34'd0);
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t;
    endfunction

    // REDUCE walks the base as the multiplier bits against a=1, so any base is reduced.
    always_comb begin
        mul_a = 32'd1;
        mul_b = base_q;
        case (state_q)
            MUL:     begin mul_a = res_q; mul_b = sq_q; end
            SQR:     begin mul_a = sq_q;  mul_b = sq_q; end
            default: ;
        endcase
    end

    assign acc_nxt  = mm_step(acc_q, mul_a, mul_b[~cnt_q], mod_q);
    assign mul_last = (cnt_q == 5'd31);
    assign idx_inc  = idx_q + 5'd1;

    // NEXT is folded into the SQR exit so it costs no cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (modulus == 32'd0) ? FIN : REDUCE;
            REDUCE:  if (mul_last) state_d = (CONST_TIME || exp_q[idx_q]) ? MUL : SQR;
            MUL:     if (mul_last) state_d = SQR;
            SQR: begin
                if (mul_last) begin
                    if (idx_q == 5'd31)                    state_d = FIN;
                    else if (CONST_TIME || exp_q[idx_inc]) state_d = MUL;
                    else                                   state_d = SQR;
                end
            end
            NEXT:    state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            cnt_q   <= 5'd0;
            acc_q   <= 34'd0;
            res_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q <= 5'd0;
                        cnt_q <= 5'd0;
                        acc_q <= 34'd0;
                        err_q <= (modulus == 32'd0);
                        res_q <= (modulus <= 32'd1) ? 32'd0 : 32'd1;
                    end
                end
                REDUCE, MUL, SQR: begin
                    cnt_q <= cnt_q + 5'd1;
                    acc_q <= mul_last ? 34'd0 : acc_nxt;
                    if (mul_last) begin
                        // A MUL on a zero exponent bit only happens in constant-time mode; its product is dropped.
                        if (state_q == MUL) begin
                            if (exp_q[idx_q]) res_q <= acc_nxt[31:0];
                        end else begin
                            sq_q <= acc_nxt[31:0];
                        end
                        if (state_q == SQR && idx_q != 5'd31) idx_q <= idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && start) begin
            base_q <= base;
            exp_q  <= exponent;
            mod_q  <= modulus;
        end
    end

    assign result = {32'd0, res_q};
    assign done   = (state_q == FIN);
    assign busy   = (state_q != IDLE);
    assign err    = err_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboard bench for mod_exp_engine: directed vectors push expected result/err/done-cycle, a monitor checks each done.
module tb_mod_exp_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base = '0, exponent = '0, modulus = '0;
    logic [63:0] result;
    logic        done, busy, err;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    mod_exp_engine dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
        .modulus(modulus), .result(result), .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int lat(input logic [31:0] e, input logic [31:0] m);
        if (m == 32'd0) return 1;
`ifdef MOD_EXP_CONST_TIME_EN
        return 2081;
`else
        return 1057 + 32 * $countones(e);
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("result", result, x.res);
                chk("err", {63'd0, err}, {63'd0, x.err});
                chk("done_cycle", 64'(cyc), 64'(x.due));
            end
        end
    end

    task automatic issue(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                         input logic [63:0] r, input logic er, input bit push, output int l);
        exp_t x;
        @(negedge clk);
        base = b; exponent = e; modulus = m; start = 1'b1;
        l = lat(e, m);
        x.res = r; x.err = er; x.due = cyc + l;
        if (push) q.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                       input logic [63:0] r, input logic er);
        int l;
        issue(b, e, m, r, er, 1'b1, l);
        repeat (l + 3) @(negedge clk);
    endtask

    initial begin
        int l;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        rst = 1'b0;

        run(32'd5, 32'd3, 32'd23, 64'd10, 1'b0);
        run(32'd30, 32'd2, 32'd7, 64'd4, 1'b0);
        run(32'd2, 32'd10, 32'd1000, 64'd24, 1'b0);
        run(32'd9, 32'd0, 32'd1, 64'd0, 1'b0);
        run(32'd9, 32'd0, 32'd5, 64'd1, 1'b0);
        run(32'd7, 32'd13, 32'd11, 64'd2, 1'b0);
        run(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB, 64'd16, 1'b0);
        run(32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 64'd1, 1'b0);

        // Illegal modulus: err and result hold until the next accepted start.
        run(32'd1234, 32'd77, 32'd0, 64'd0, 1'b1);
        chk("err_hold", {63'd0, err}, 64'd1);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        run(32'd5, 32'd3, 32'd23, 64'd10, 1'b0);

        // Start during FIN is dropped.
        issue(32'd4, 32'd5, 32'd0, 64'd0, 1'b1, 1'b1, l);
        base = 32'd5; exponent = 32'd3; modulus = 32'd23; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2200) @(negedge clk);
        run(32'd9, 32'd0, 32'd5, 64'd1, 1'b0);

        // Start while busy is ignored.
        issue(32'd5, 32'd3, 32'd23, 64'd10, 1'b0, 1'b1, l);
        repeat (98) @(negedge clk);
        chk("busy_mid", {63'd0, busy}, 64'd1);
        base = 32'd3; exponent = 32'd4; modulus = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (l) @(negedge clk);

        // Reset mid-run abandons the computation.
        issue(32'd5, 32'd3, 32'd23, 64'd10, 1'b0, 1'b0, l);
        repeat (498) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_result", result, 64'd0);
        chk("rstmid_done", {63'd0, done}, 64'd0);
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_err", {63'd0, err}, 64'd0);
        repeat (2200) @(negedge clk);
        run(32'd30, 32'd2, 32'd7, 64'd4, 1'b0);

        while (q.size() != 0) begin
            void'(q.pop_front());
            chk("missing_done", 64'd0, 64'd1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
